// File: rtl/uart_loader_if.sv
// UART loader bus: receive byte stream, response byte handshake,
// memory write port and core control.
interface uart_loader_if #(
  parameter int ADDR_W     = 5,
  parameter int word_width = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [word_width-1:0] mem_wdata;
  logic                  core_reset;
  logic                  busy;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    output core_reset,
    output busy
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    input  core_reset,
    input  busy
  );
endinterface

// File: rtl/uart_loader.sv
// Byte-stream program loader: LOAD/RUN/HALT commands, little-endian
// word assembly into memory, single-byte ACK/NAK response.
module uart_loader #(
  parameter int word_width     = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input logic   clk,
  input logic   reset_n,
  uart_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'hC3;
  localparam logic [7:0] CMD_HALT = 8'h3C;
  localparam logic [7:0] ACK      = 8'h4B;
  localparam logic [7:0] NAK      = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_CNT,
    GET_DATA,
    WRITE,
    RESP
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     addr_d;
  logic [8:0]            cnt_q;
  logic [8:0]            cnt_d;
  logic [1:0]            idx_q;
  logic [23:0]           word_q;
  logic [TW-1:0]         tmo_q;
  logic [TW-1:0]         tmo_d;
  logic                  tmo_hit;
  logic                  in_get;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  mem_write_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [word_width-1:0] mem_wdata_q;
  logic                  core_reset_q;

  assign addr_d  = addr_q + 1'b1;
  assign cnt_d   = cnt_q - 9'd1;
  assign tmo_d   = tmo_q + 1'b1;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign in_get  = (state_q == GET_ADDR) ||
                   (state_q == GET_CNT)  ||
                   (state_q == GET_DATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
    end else begin
      mem_write_q <= 1'b0;
      // Silence while collecting bytes: count, then abandon with NAK
      if (in_get && !bus.rx_valid) begin
        if (tmo_hit) begin
          state_q    <= RESP;
          tx_data_q  <= NAK;
          tx_valid_q <= 1'b1;
        end else begin
          tmo_q <= tmo_d;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.rx_valid) begin
              unique case (1'b1)
                bus.rx_data == CMD_LOAD: begin
                  core_reset_q <= 1'b1;
                  tmo_q        <= '0;
                  state_q      <= GET_ADDR;
                end
                bus.rx_data == CMD_RUN: begin
                  core_reset_q <= 1'b0;
                  tx_data_q    <= ACK;
                  tx_valid_q   <= 1'b1;
                  state_q      <= RESP;
                end
                bus.rx_data == CMD_HALT: begin
                  core_reset_q <= 1'b1;
                  tx_data_q    <= ACK;
                  tx_valid_q   <= 1'b1;
                  state_q      <= RESP;
                end
                default: begin
                  tx_data_q  <= NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= RESP;
                end
              endcase
            end
          end
          GET_ADDR: begin
            addr_q  <= bus.rx_data[ADDR_W-1:0];
            tmo_q   <= '0;
            state_q <= GET_CNT;
          end
          GET_CNT: begin
            cnt_q   <= (bus.rx_data == 8'h00) ? 9'd256
                                              : {1'b0, bus.rx_data};
            idx_q   <= 2'd0;
            tmo_q   <= '0;
            state_q <= GET_DATA;
          end
          GET_DATA: begin
            tmo_q <= '0;
            idx_q <= idx_q + 2'd1;
            unique case (idx_q)
              2'd0: word_q[7:0]   <= bus.rx_data;
              2'd1: word_q[15:8]  <= bus.rx_data;
              2'd2: word_q[23:16] <= bus.rx_data;
              default: begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= word_width'({bus.rx_data, word_q});
                state_q     <= WRITE;
              end
            endcase
          end
          WRITE: begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            tmo_q  <= '0;
            if (cnt_q == 9'd1) begin
              tx_data_q  <= ACK;
              tx_valid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              state_q <= GET_DATA;
            end
          end
          RESP: begin
            if (tx_valid_q && bus.tx_ready) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_reset = core_reset_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed command scenarios plus random
// loads/commands checked against a byte-stream protocol model.
module tb_uart_loader;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(5), .word_width(32)) bus ();

  uart_loader #(
    .word_width(32),
    .ADDR_W(5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int multi = 0;
  bit prev_mw = 1'b0;
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  txq[$];
  logic [7:0]  dq[$];
  logic        exp_cr;

  always @(negedge clk) begin
    if (bus.mem_write) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      if (prev_mw) multi <= multi + 1;
    end
    prev_mw <= bus.mem_write;
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txv"}, 32'(bus.tx_valid), 0);
    chk({tag, "_txd"}, 32'(bus.tx_data), 0);
    chk({tag, "_mw"}, 32'(bus.mem_write), 0);
    chk({tag, "_ma"}, 32'(bus.mem_addr), 0);
    chk({tag, "_md"}, bus.mem_wdata, 0);
    chk({tag, "_cr"}, 32'(bus.core_reset), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp);
    int n = 0;
    while (txq.size() == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_ntx"}, 32'(txq.size()), 1);
    if (txq.size() > 0) chk({tag, "_tx"}, 32'(txq.pop_front()), 32'(exp));
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    txq.delete();
  endtask

  // LOAD expected result: word k goes to (start + k) mod 32, bytes LE
  task automatic do_load(input string tag, input logic [7:0] a,
                         input logic [7:0] nb);
    int n;
    logic [31:0] ew;
    wa.delete();
    wd.delete();
    txq.delete();
    n = (nb == 8'h00) ? 256 : int'(nb);
    send(8'hA5);
    send(a);
    send(nb);
    foreach (dq[i]) send(dq[i]);
    expect_resp(tag, 8'h4B);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'(n));
    for (int k = 0; k < n && k < wa.size(); k++) begin
      ew = {dq[4*k+3], dq[4*k+2], dq[4*k+1], dq[4*k]};
      chk({tag, "_addr"}, 32'(wa[k]), 32'((int'(a) + k) % 32));
      chk({tag, "_data"}, wd[k], ew);
    end
    exp_cr = 1'b1;
    chk({tag, "_cr"}, 32'(bus.core_reset), 32'(exp_cr));
  endtask

  task automatic cmd(input string tag, input logic [7:0] b);
    logic [7:0] er;
    txq.delete();
    er = 8'h3F;
    if (b == 8'hC3) begin
      er = 8'h4B;
      exp_cr = 1'b0;
    end else if (b == 8'h3C) begin
      er = 8'h4B;
      exp_cr = 1'b1;
    end
    send(b);
    expect_resp(tag, er);
    chk({tag, "_cr"}, 32'(bus.core_reset), 32'(exp_cr));
  endtask

  initial begin
    int unstable;
    int n;
    logic [7:0] a;
    logic [7:0] b;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    exp_cr = 1'b1;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;

    dq.delete();
    for (int i = 0; i < 8; i++) dq.push_back(8'(8'h11 * (i + 1)));
    do_load("load", 8'h03, 8'h02);
    chk("load_hold_a", 32'(bus.mem_addr), 4);
    chk("load_hold_d", bus.mem_wdata, 32'h88776655);

    dq.delete();
    for (int i = 0; i < 8; i++) dq.push_back(8'($urandom));
    do_load("wrap", 8'h1F, 8'h02);

    cmd("run", 8'hC3);
    cmd("halt", 8'h3C);
    cmd("other", 8'h12);

    wa.delete();
    txq.delete();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hAA);
    repeat (TMO - 5) @(negedge clk);
    chk("tmo_early", 32'(bus.tx_valid), 0);
    expect_resp("tmo", 8'h3F);
    chk("tmo_nwr", 32'(wa.size()), 0);
    chk("tmo_cr", 32'(bus.core_reset), 1);

    bus.tx_ready = 1'b0;
    txq.delete();
    unstable = 0;
    send(8'h12);
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3F) unstable++;
    end
    send(8'hC3);
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3F) unstable++;
    end
    chk("bp_stable", 32'(unstable), 0);
    chk("bp_held", 32'(txq.size()), 0);
    bus.tx_ready = 1'b1;
    expect_resp("bp", 8'h3F);
    chk("bp_drop_cr", 32'(bus.core_reset), 32'(exp_cr));

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom);
        n = $urandom_range(1, 3);
        dq.delete();
        for (int i = 0; i < 4 * n; i++) dq.push_back(8'($urandom));
        do_load("rload", a, 8'(n));
      end else begin
        case ($urandom_range(0, 2))
          0: b = 8'hC3;
          1: b = 8'h3C;
          default: begin
            b = 8'($urandom);
            while (b == 8'hA5 || b == 8'hC3 || b == 8'h3C) b = 8'($urandom);
          end
        endcase
        cmd("rcmd", b);
      end
    end

    wa.delete();
    txq.delete();
    send(8'hA5);
    send(8'h05);
    send(8'h01);
    send(8'hDE);
    send(8'hAD);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset("abort");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_cr = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_nwr", 32'(wa.size()), 0);
    chk("abort_ntx", 32'(txq.size()), 0);
    cmd("abort_run", 8'hC3);

    chk("wr_pulse", 32'(multi), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter word_width, default 32, memory data width; fixed at 32 (four bytes per word).
REQ-002 SHALL have parameter ADDR_W, default 5, memory word address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000000, inter-byte timeout in clk cycles (100 ms at 50 MHz).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port tx_data  output  8  response byte to UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  response byte pending.
REQ-010 SHALL have port tx_ready  input  1  transmitter can accept a byte.
REQ-011 SHALL have port mem_write  output  1  one-cycle memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-013 SHALL have port mem_wdata  output  word_width  memory write data.
REQ-014 SHALL have port core_reset  output  1  active-high hold-in-reset to core.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, RESP.
REQ-017 IDLE, byte 0xA5 (LOAD): SHALL set core_reset=1 and go to GET_ADDR on the next cycle.
REQ-018 IDLE, byte 0xC3 (RUN): SHALL clear core_reset and go to RESP with tx_data=0x4B (ACK).
REQ-019 IDLE, byte 0x3C (HALT): SHALL set core_reset=1 and go to RESP with tx_data=0x4B.
REQ-020 IDLE, any other byte: SHALL go to RESP with tx_data=0x3F (NAK); core_reset unchanged.
REQ-021 GET_ADDR: SHALL latch rx_data[ADDR_W-1:0] as start address; upper bits ignored; go to GET_CNT.
REQ-022 GET_CNT: SHALL latch word count N = rx_data, with 0x00 meaning 256; go to GET_DATA, byte index 0.
REQ-023 GET_DATA: SHALL assemble bytes little-endian (first byte -> bits 7:0, fourth -> bits 31:24).
REQ-024 Fourth byte accepted at cycle T: SHALL enter WRITE; mem_write=1 for exactly cycle T+1, with mem_addr and mem_wdata stable in that cycle.
REQ-025 WRITE: SHALL increment address modulo 2^ADDR_W (31 -> 0 wraps) and decrement remaining count.
REQ-026 WRITE: SHALL go to RESP with tx_data=0x4B if remaining count reaches 0, else back to GET_DATA.
REQ-027 mem_write SHALL never be asserted outside WRITE; mem_addr/mem_wdata hold last values otherwise.
REQ-028 RESP: SHALL assert tx_valid with tx_data stable until the cycle where tx_valid && tx_ready, then drop tx_valid next cycle and return to IDLE.
REQ-029 tx_valid SHALL NOT depend combinationally on tx_ready.
REQ-030 rx_valid during RESP or WRITE: SHALL drop the byte silently with no state change.
REQ-031 Timeout: in GET_ADDR, GET_CNT or GET_DATA, TIMEOUT_CYCLES cycles without rx_valid SHALL go to RESP with tx_data=0x3F.
REQ-032 Timeout recovery: SHALL discard the partial word (no mem_write); already-written words remain written; core_reset stays 1.
REQ-033 The timeout counter SHALL reset on every accepted byte and on entry to GET_ADDR; it is saturating and inactive in IDLE, WRITE and RESP.

Reset
REQ-034 On reset_n low, SHALL asynchronously force: state=IDLE, tx_valid=0, tx_data=0x00, mem_write=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, all counters 0.
REQ-035 Reset asserted mid-LOAD or mid-RESP SHALL abort with no further mem_write or tx_valid; operation resumes in IDLE after reset_n rises.

Verification
REQ-036 Bench SHALL cover LOAD basic: bytes A5,03,02, 11,22,33,44, 55,66,77,88 -> writes addr3=0x44332211, addr4=0x88776655, each mem_write one cycle; then tx 0x4B; core_reset=1.
REQ-037 Bench SHALL cover LOAD wrap: A5,1F,02 plus 8 data bytes -> writes to addr 31 then addr 0; ACK.
REQ-038 Bench SHALL cover RUN/HALT: C3 -> core_reset 0, tx 0x4B; 3C -> core_reset 1, tx 0x4B; 0x12 -> tx 0x3F, core_reset unchanged.
REQ-039 Bench SHALL cover timeout: A5,00,01,AA then silence for TIMEOUT_CYCLES (reduced to 100 in sim) -> no mem_write, tx 0x3F, state IDLE.
REQ-040 Bench SHALL cover backpressure: tx_ready low for 50 cycles during RESP -> tx_valid and tx_data stable; single transfer when tx_ready rises; byte sent during RESP is dropped.
REQ-041 Bench SHALL cover reset abort: reset_n low after 2 of 4 data bytes -> all outputs at reset values; a following C3 is handled normally.
